fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_pkg.sv | 29 ++
 rtl/fnd_scan_ctrl_tick_gen.sv | 29 ++
 rtl/fnd_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
// Codes 0x00-0x0F are hex/blank, and codes 0x10-0x17 are the letter glyphs.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [4:0] code_t;
    typedef code_t [NUM_DIGITS-1:0] code_vec_t;

    localparam code_t BLANK_CODE = 5'h0F;
    localparam code_t CODE_E     = 5'h10;
    localparam code_t CODE_R     = 5'h11;
    localparam code_t CODE_RDOT  = 5'h12;
    localparam code_t CODE_T     = 5'h13;
    localparam code_t CODE_O     = 5'h14;
    localparam code_t CODE_U     = 5'h15;
    localparam code_t CODE_H     = 5'h16;
    localparam code_t CODE_D     = 5'h17;

    // One complete display frame, held both as the shadow copy and as the active copy.
    typedef struct packed {
        code_vec_t               codes;
        logic [NUM_DIGITS-1:0]   mask;
        logic                    lz;
    } frame_t;

    localparam frame_t FRAME_RST = '{codes: {NUM_DIGITS{BLANK_CODE}}, mask: '0, lz: 1'b0};

endpackage

// File: rtl/fnd_scan_ctrl_tick_gen.sv
// Free-running modulo-DIV counter that emits a single-cycle tick on its last count.
// While clr is high, the counter is held at zero and no tick is emitted.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit scan controller: it multiplexes the display codes onto bcd and drives the commons with a ghost guard.
// It also provides frame-atomic shadow loads, leading-zero blanking and per-digit blinking.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       load,
    input  logic [4:0] digit0,
    input  logic [4:0] digit1,
    input  logic [4:0] digit2,
    input  logic [4:0] digit3,
    input  logic [3:0] blink_mask,
    input  logic       lz_en,
    output logic       pending,
    output logic [4:0] bcd,
    output logic [3:0] fnd_com
);

    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

    logic       scan_tick;
    logic       blink_tick;
    logic       boundary;

    frame_t     in_frame;
    frame_t     shadow;
    frame_t     act;
    frame_t     act_nxt;
    logic       pending_nxt;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic       armed;
    logic       armed_nxt;
    logic       phase;
    logic       phase_nxt;
    code_t      bcd_nxt;
    logic [3:0] com_nxt;

    tick_gen #(.DIV(DIV)) u_scan_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!en),
        .tick    (scan_tick)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .tick    (blink_tick)
    );

    // Blink blanking has priority, then leading-zero blanking (digit 0 never blanks), then the active code.
    function automatic code_t digit_code(input code_vec_t codes, input logic [NUM_DIGITS-1:0] mask,
                                         input logic lz, input logic [1:0] sel, input logic ph);
        logic z3, z2, z1, lz_blank;
        z3 = (codes[3] == 5'h00);
        z2 = z3 && (codes[2] == 5'h00);
        z1 = z2 && (codes[1] == 5'h00);
        case (sel)
            2'd3:    lz_blank = lz && z3;
            2'd2:    lz_blank = lz && z2;
            2'd1:    lz_blank = lz && z1;
            default: lz_blank = 1'b0;
        endcase
        if (!ph && mask[sel]) begin
            digit_code = BLANK_CODE;
        end else if (lz_blank) begin
            digit_code = BLANK_CODE;
        end else begin
            digit_code = codes[sel];
        end
    endfunction

    assign in_frame = '{codes: {digit3, digit2, digit1, digit0}, mask: blink_mask, lz: lz_en};

    // The first tick after enable only arms the scan, so that digit 0 lights after one full DIV count; it also counts as a frame boundary.
    assign boundary = scan_tick && (!armed || idx == 2'd3);

    always_comb begin
        act_nxt     = act;
        pending_nxt = pending;
        if (boundary) begin
            if (load) begin
                act_nxt = in_frame;
            end else if (pending) begin
                act_nxt = shadow;
            end
            pending_nxt = 1'b0;
        end else if (load) begin
            pending_nxt = 1'b1;
        end

        idx_nxt   = idx;
        armed_nxt = armed;
        if (!en) begin
            idx_nxt   = 2'd0;
            armed_nxt = 1'b0;
        end else if (scan_tick) begin
            if (armed) begin
                idx_nxt = idx + 2'd1;
            end else begin
                armed_nxt = 1'b1;
            end
        end

        phase_nxt = blink_tick ? ~phase : phase;

        // bcd tracks the post-edge state, so new codes appear one cycle after the boundary tick.
        bcd_nxt = (en && armed_nxt) ? digit_code(act_nxt.codes, act_nxt.mask, act_nxt.lz, idx_nxt, phase_nxt)
                                    : BLANK_CODE;
        com_nxt = (!en || scan_tick || !armed) ? 4'b1111 : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= FRAME_RST;
            act     <= FRAME_RST;
            pending <= 1'b0;
            idx     <= 2'd0;
            armed   <= 1'b0;
            phase   <= 1'b1;
            bcd     <= BLANK_CODE;
            fnd_com <= 4'b1111;
        end else begin
            if (load) begin
                shadow <= in_frame;
            end
            act     <= act_nxt;
            pending <= pending_nxt;
            idx     <= idx_nxt;
            armed   <= armed_nxt;
            phase   <= phase_nxt;
            bcd     <= bcd_nxt;
            fnd_com <= com_nxt;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl at DIV=4 and BLINK_DIV=8: table vectors, corner-case sequences and random traffic,
// all checked every cycle against a count-based reference model.
module tb_fnd_scan_ctrl;
    localparam int DIV  = 4;
    localparam int BDIV = 8;

    logic       clk = 1'b0;
    logic       reset_n, en, load, lz_en;
    logic [4:0] digit0, digit1, digit2, digit3;
    logic [3:0] blink_mask;
    logic       pending;
    logic [4:0] bcd;
    logic [3:0] fnd_com;

    int ncmp = 0;
    int nerr = 0;

    fnd_scan_ctrl #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .blink_mask(blink_mask), .lz_en(lz_en),
        .pending(pending), .bcd(bcd), .fnd_com(fnd_com)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // Reference model: the scan position is derived from counts of enabled edges and ticks,
    // and the blink phase is derived from the number of edges since reset.
    int         edges_rst, run_edges, ticks;
    logic [4:0] ma [4];
    logic [4:0] ms [4];
    bit         mam [4];
    bit         msm [4];
    bit         mal, msl, m_pend;
    logic [4:0] exp_bcd;
    logic [3:0] exp_com;

    function automatic logic [4:0] ref_code(int i, bit ph);
        bit allz = 1'b1;
        if (!ph && mam[i]) return 5'h0F;
        for (int j = i; j < 4; j++) if (ma[j] != 5'h00) allz = 1'b0;
        if (mal && i > 0 && allz) return 5'h0F;
        return ma[i];
    endfunction

    function automatic bit model_phase();
        return ((edges_rst / BDIV) % 2) == 0;
    endfunction

    task automatic model_reset();
        edges_rst = 0; run_edges = 0; ticks = 0;
        for (int j = 0; j < 4; j++) begin
            ma[j] = 5'h0F; ms[j] = 5'h0F; mam[j] = 1'b0; msm[j] = 1'b0;
        end
        mal = 1'b0; msl = 1'b0; m_pend = 1'b0;
        exp_bcd = 5'h0F; exp_com = 4'hF;
    endtask

    task automatic model_edge();
        logic [4:0] din [4];
        bit tick, bnd;
        int idxb, idxa;
        din = '{digit0, digit1, digit2, digit3};
        tick = en && (run_edges % DIV == DIV - 1);
        idxb = (ticks == 0) ? 0 : (ticks - 1) % 4;
        bnd  = tick && (ticks == 0 || idxb == 3);
        if (bnd) begin
            if (load) begin
                for (int j = 0; j < 4; j++) begin ma[j] = din[j]; mam[j] = blink_mask[j]; end
                mal = lz_en;
            end else if (m_pend) begin
                for (int j = 0; j < 4; j++) begin ma[j] = ms[j]; mam[j] = msm[j]; end
                mal = msl;
            end
            m_pend = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        if (load) begin
            for (int j = 0; j < 4; j++) begin ms[j] = din[j]; msm[j] = blink_mask[j]; end
            msl = lz_en;
        end
        exp_com = (!en || tick || ticks == 0) ? 4'hF : (4'hF ^ (4'h1 << idxb));
        if (en) begin
            run_edges++;
            if (tick) ticks++;
        end else begin
            run_edges = 0;
            ticks = 0;
        end
        edges_rst++;
        idxa = (ticks == 0) ? 0 : (ticks - 1) % 4;
        exp_bcd = (en && ticks > 0) ? ref_code(idxa, model_phase()) : 5'h0F;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge();
        #1;
        chk("bcd", bcd, exp_bcd);
        chk("fnd_com", fnd_com, exp_com);
        chk("pending", pending, m_pend);
    endtask

    task automatic wait_com(input logic [3:0] target, input string nm);
        int n = 0;
        while (fnd_com !== target && n < 64) begin step(); n++; end
        chk(nm, fnd_com, target);
    endtask

    task automatic wait_applied();
        int n = 0;
        while (pending === 1'b1 && n < 64) begin step(); n++; end
        chk("pending_clear", pending, 1'b0);
    endtask

    task automatic load_frame(input logic [19:0] codes, input logic [3:0] m, input logic l);
        {digit3, digit2, digit1, digit0} = codes;
        blink_mask = m; lz_en = l; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_com", fnd_com, 4'hF);
        chk("rst_bcd", bcd, 5'h0F);
        chk("rst_pending", pending, 1'b0);
        model_reset();
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [4:0] rnd_code();
        if ($urandom_range(0, 3) == 0) return 5'h00;
        return 5'($urandom_range(0, 23));
    endfunction

    typedef struct {
        logic [19:0] codes;
        logic        lz;
        logic [19:0] expv;
    } vec_t;

    vec_t       vecs [7];
    logic [3:0] com_seq [16];
    logic [4:0] bcd_seq [16];

    initial begin
        int n, saw_blank, saw_lit;

        vecs[0] = '{{5'h00, 5'h00, 5'h07, 5'h00}, 1'b1, {5'h0F, 5'h0F, 5'h07, 5'h00}};
        vecs[1] = '{{5'h00, 5'h00, 5'h00, 5'h00}, 1'b1, {5'h0F, 5'h0F, 5'h0F, 5'h00}};
        vecs[2] = '{{5'h00, 5'h00, 5'h00, 5'h00}, 1'b0, {5'h00, 5'h00, 5'h00, 5'h00}};
        vecs[3] = '{{5'h00, 5'h05, 5'h00, 5'h00}, 1'b1, {5'h0F, 5'h05, 5'h00, 5'h00}};
        vecs[4] = '{{5'h00, 5'h16, 5'h00, 5'h17}, 1'b1, {5'h0F, 5'h16, 5'h00, 5'h17}};
        vecs[5] = '{{5'h09, 5'h00, 5'h00, 5'h00}, 1'b1, {5'h09, 5'h00, 5'h00, 5'h00}};
        vecs[6] = '{{5'h00, 5'h00, 5'h00, 5'h0C}, 1'b1, {5'h0F, 5'h0F, 5'h0F, 5'h0C}};
        com_seq = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                    4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
        bcd_seq = '{5'd4, 5'd4, 5'd4, 5'd3, 5'd3, 5'd3, 5'd3, 5'd2,
                    5'd2, 5'd2, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd4};

        reset_n = 1'b0; en = 1'b0; load = 1'b0; lz_en = 1'b0; blink_mask = 4'h0;
        digit0 = 5'h0; digit1 = 5'h0; digit2 = 5'h0; digit3 = 5'h0;
        model_reset();
        step(); step();
        reset_n = 1'b1; en = 1'b1;

        // Scan order and ghost guard
        load_frame({5'd1, 5'd2, 5'd3, 5'd4}, 4'h0, 1'b0);
        wait_applied();
        wait_com(4'hE, "wait_scan_start");
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("scan_com_%0d", j), fnd_com, com_seq[j]);
            chk($sformatf("scan_bcd_%0d", j), bcd, bcd_seq[j]);
            step();
        end

        // Atomic mid-frame update
        wait_com(4'hE, "wait_atomic_d0");
        wait_com(4'hD, "wait_atomic_d1");
        load_frame({5'h10, 5'h11, 5'h11, 5'h14}, 4'h0, 1'b0);
        chk("atomic_pending_set", pending, 1'b1);
        wait_com(4'hB, "wait_atomic_old_d2");
        chk("atomic_old_d2", bcd, 5'd2);
        wait_com(4'h7, "wait_atomic_old_d3");
        chk("atomic_old_d3", bcd, 5'd1);
        chk("atomic_pending_hold", pending, 1'b1);
        wait_applied();
        wait_com(4'hE, "wait_erro_d0"); chk("erro_d0", bcd, 5'h14);
        wait_com(4'hD, "wait_erro_d1"); chk("erro_d1", bcd, 5'h11);
        wait_com(4'hB, "wait_erro_d2"); chk("erro_d2", bcd, 5'h11);
        wait_com(4'h7, "wait_erro_d3"); chk("erro_d3", bcd, 5'h10);

        // Coincident load on the 3->0 tick
        wait_com(4'hB, "wait_coin_d2");
        wait_com(4'h7, "wait_coin_d3");
        step(); step();
        load_frame({5'h16, 5'h12, 5'h13, 5'h15}, 4'h0, 1'b0);
        chk("coin_com_guard", fnd_com, 4'hF);
        chk("coin_bcd_d0", bcd, 5'h15);
        chk("coin_pending", pending, 1'b0);
        for (int j = 0; j < 6; j++) begin
            step();
            chk("coin_pending_low", pending, 1'b0);
        end

        // Table-driven leading-zero vectors
        for (int v = 0; v < 7; v++) begin
            load_frame(vecs[v].codes, 4'h0, vecs[v].lz);
            wait_applied();
            for (int i = 0; i < 4; i++) begin
                wait_com(4'hF ^ (4'h1 << i), $sformatf("wait_vec%0d_d%0d", v, i));
                chk($sformatf("vec%0d_d%0d", v, i), bcd, vecs[v].expv[i*5 +: 5]);
            end
        end

        // Blink on digit 0; each en gap shifts scan alignment against the blink phase
        load_frame({5'd1, 5'd2, 5'd3, 5'd4}, 4'h1, 1'b0);
        wait_applied();
        saw_blank = 0; saw_lit = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 32; c++) begin
                step();
                if (fnd_com === 4'hE) begin
                    chk("blink_d0", bcd, model_phase() ? 5'd4 : 5'h0F);
                    if (model_phase()) saw_lit++; else saw_blank++;
                end else if (fnd_com === 4'hD) begin
                    chk("blink_d1_unaffected", bcd, 5'd3);
                end
            end
            en = 1'b0;
            for (int k = 0; k <= r; k++) step();
            en = 1'b1;
        end
        chk("blink_both_phases_seen", (saw_blank > 0 && saw_lit > 0), 1'b1);

        // Asynchronous reset mid-scan while a load is pending
        wait_com(4'hD, "wait_rst_d1");
        load_frame({5'd9, 5'd9, 5'd9, 5'd9}, 4'h0, 1'b0);
        chk("rst_pre_pending", pending, 1'b1);
        do_reset();
        n = 0;
        while (fnd_com !== 4'hE && n < 20) begin step(); n++; end
        chk("rst_first_digit_latency", n, 5);
        chk("rst_first_digit_bcd", bcd, 5'h0F);

        // Disable, load while disabled, re-enable
        en = 1'b0;
        step();
        chk("dis_com", fnd_com, 4'hF);
        chk("dis_bcd", bcd, 5'h0F);
        load_frame({5'd5, 5'd6, 5'd7, 5'd8}, 4'h0, 1'b0);
        chk("dis_pending", pending, 1'b1);
        for (int j = 0; j < 10; j++) step();
        en = 1'b1;
        n = 0;
        while (fnd_com !== 4'hE && n < 20) begin step(); n++; end
        chk("reen_first_digit_latency", n, 5);
        chk("reen_d0_bcd", bcd, 5'd8);
        chk("reen_pending", pending, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(0, 79) != 0);
            load = ($urandom_range(0, 9) == 0);
            if (load) begin
                digit0 = rnd_code(); digit1 = rnd_code(); digit2 = rnd_code(); digit3 = rnd_code();
                blink_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                lz_en = 1'($urandom_range(0, 1));
            end
            step();
            load = 1'b0;
            if (c % 750 == 749) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
